// File: rtl/debug_pkg.sv
// Shared widths, fixed read-map addresses and small word-building helpers
// for the VGA debug register bank.
package debug_pkg;

    localparam int DBG_DATA_W = 32;
    localparam int DBG_ADDR_W = 7;
    localparam int FIFO_W     = DBG_ADDR_W + DBG_DATA_W;

    localparam logic [DBG_ADDR_W-1:0] ADDR_CYCLE  = 7'h7C;
    localparam logic [DBG_ADDR_W-1:0] ADDR_FRAME  = 7'h7D;
    localparam logic [DBG_ADDR_W-1:0] ADDR_STATUS = 7'h7E;
    localparam logic [DBG_ADDR_W-1:0] ADDR_ID     = 7'h7F;
    localparam logic [DBG_DATA_W-1:0] DBG_ID      = 32'hDEB6_0001;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    function automatic logic [DBG_DATA_W-1:0] status_word(input logic [7:0] drops,
                                                          input logic [7:0] fill,
                                                          input logic       frz);
        return {drops, 8'h00, fill, 7'h00, frz};
    endfunction

endpackage

// File: rtl/debug_wr_fifo.sv
// Synchronous show-ahead FIFO staging debug writes until the next drain window.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module debug_wr_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PTR_W = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/debug_reg_bank.sv
// Debug register bank for the VGA overlay: staged writes drain into the bank only
// during vertical sync, plus cycle/frame counters, status and ID words.
module debug_reg_bank
    import debug_pkg::*;
#(
    parameter int   NUM_REGS   = 32,
    parameter int   FIFO_DEPTH = 8,
    parameter logic VS_POL     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DBG_ADDR_W-1:0] wr_addr,
    input  logic [DBG_DATA_W-1:0] wr_data,
    input  logic                  vs,
    input  logic                  freeze,
    input  logic                  clr,
    input  logic [DBG_ADDR_W-1:0] debug_addr,
    output logic [DBG_DATA_W-1:0] debug_data
);

    localparam int BANK_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DBG_ADDR_W-1:0] NUM_REGS_A = DBG_ADDR_W'(NUM_REGS);

    logic [DBG_DATA_W-1:0] bank_r [NUM_REGS];
    logic [FIFO_W-1:0]     fifo_dout_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  window_s;
    logic [DBG_ADDR_W-1:0] pop_addr_s;
    logic                  pop_hit_s;
    logic                  run_r;
    logic                  vs_q_r;
    logic [DBG_DATA_W-1:0] cycle_cnt_r;
    logic [DBG_DATA_W-1:0] frame_cnt_r;
    logic [7:0]            drop_cnt_r;
    logic [DBG_DATA_W-1:0] rd_mux_s;
    logic [DBG_DATA_W-1:0] debug_data_r;

    // run_r keeps wr_ready low until the first cycle after reset release.
    assign wr_ready   = run_r && !fifo_full_s;
    assign push_s     = wr_valid && wr_ready && !clr;
    assign window_s   = (vs == VS_POL) && !freeze;
    assign pop_s      = window_s && !fifo_empty_s && !clr;
    assign pop_addr_s = fifo_dout_s[FIFO_W-1:DBG_DATA_W];
    assign pop_hit_s  = (pop_addr_s < NUM_REGS_A);
    assign debug_data = debug_data_r;

    debug_wr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (clr),
        .wr_data ({wr_addr, wr_data}),
        .rd_data (fifo_dout_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Bank contents: cleared by reset or clr, written by each in-range popped entry.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            for (int i = 0; i < NUM_REGS; i++) bank_r[i] <= 32'h0;
        end else if (pop_s && pop_hit_s) begin
            bank_r[pop_addr_s[BANK_AW-1:0]] <= fifo_dout_s[DBG_DATA_W-1:0];
        end
    end

    // Saturating count of popped entries whose address is outside the bank.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            drop_cnt_r <= 8'h00;
        end else if (pop_s && !pop_hit_s) begin
            drop_cnt_r <= sat_inc8(drop_cnt_r);
        end
    end

    // Free-running counters and VSYNC edge tracking; clr leaves these alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_r       <= 1'b0;
            vs_q_r      <= ~VS_POL;
            cycle_cnt_r <= 32'h0;
            frame_cnt_r <= 32'h0;
        end else begin
            run_r       <= 1'b1;
            vs_q_r      <= vs;
            cycle_cnt_r <= cycle_cnt_r + 32'h1;
            if ((vs_q_r != VS_POL) && (vs == VS_POL)) frame_cnt_r <= frame_cnt_r + 32'h1;
        end
    end

    // Read map.
    always_comb begin
        rd_mux_s = 32'h0;
        case (debug_addr)
            ADDR_CYCLE:  rd_mux_s = cycle_cnt_r;
            ADDR_FRAME:  rd_mux_s = frame_cnt_r;
            ADDR_STATUS: rd_mux_s = status_word(drop_cnt_r, 8'(fifo_count_s), freeze);
            ADDR_ID:     rd_mux_s = DBG_ID;
            default: begin
                if (debug_addr < NUM_REGS_A) rd_mux_s = bank_r[debug_addr[BANK_AW-1:0]];
                else                         rd_mux_s = 32'h0;
            end
        endcase
    end

    // Registered read data; a same-cycle bank write is seen on the following read.
    always_ff @(posedge clk) begin
        if (!rstn) debug_data_r <= 32'h0;
        else       debug_data_r <= rd_mux_s;
    end

endmodule

// File: tb/tb_debug_reg_bank.sv
// Self-checking bench for debug_reg_bank: read-vector table plus hand-written
// sequences, with expected read data queued when each read address is driven.
module tb_debug_reg_bank;

    logic        clk = 1'b0;
    logic        rstn, wr_valid, wr_ready, vs, freeze, clr;
    logic [6:0]  wr_addr, debug_addr;
    logic [31:0] wr_data, debug_data;

    always #5 clk = ~clk;

    debug_reg_bank #(.NUM_REGS(32), .FIFO_DEPTH(8), .VS_POL(1'b0)) dut (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .vs(vs), .freeze(freeze), .clr(clr),
        .debug_addr(debug_addr), .debug_data(debug_data)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_bank [32];
    vec_t        rvec [7];
    logic [31:0] cyc_m, frame_m;
    logic        vs_prev_m;

    // Reference cycle and frame counters.
    always @(posedge clk) begin
        if (!rstn) begin
            cyc_m <= 32'h0; frame_m <= 32'h0; vs_prev_m <= 1'b1;
        end else begin
            cyc_m <= cyc_m + 32'h1;
            vs_prev_m <= vs;
            if (vs_prev_m && !vs) frame_m <= frame_m + 32'h1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [6:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        sb_q.push_back(exp);
        debug_addr = a;
        tick();
        e = sb_q.pop_front();
        check(name, debug_data, e);
    endtask

    task automatic read_status(input logic [7:0] drops, input logic [7:0] fill,
                               input logic frz, input string name);
        read_reg(7'h7E, {drops, 8'h00, fill, 7'h00, frz}, name);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [31:0] d);
        int n;
        wr_valid = 1'b1; wr_addr = a; wr_data = d; n = 0;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("push_ready_timeout", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        if (a < 7'd32) exp_bank[a[4:0]] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) exp_bank[i] = 32'h0;
    endtask

    initial begin
        rstn = 1'b0; wr_valid = 1'b0; wr_addr = 7'h0; wr_data = 32'h0;
        vs = 1'b1; freeze = 1'b0; clr = 1'b0; debug_addr = 7'h0;
        clear_model();
        rvec[0] = '{7'h7F, 32'hDEB6_0001};
        rvec[1] = '{7'h00, 32'h0};
        rvec[2] = '{7'h1F, 32'h0};
        rvec[3] = '{7'h20, 32'h0};
        rvec[4] = '{7'h7B, 32'h0};
        rvec[5] = '{7'h7E, 32'h0};
        rvec[6] = '{7'h7D, 32'h0};

        // Reset
        repeat (3) tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_debug_data", debug_data, 32'h0);
        rstn = 1'b1;
        tick();
        check("rel_wr_ready", 32'(wr_ready), 32'd1);
        check("rel_debug_data", debug_data, 32'h0);
        for (int i = 0; i < 7; i++) read_reg(rvec[i].addr, rvec[i].exp, "reset_vec");
        read_reg(7'h7C, cyc_m, "cycle_cnt_a");

        // Single write held until vertical sync
        push_wr(7'd3, 32'h0000_1234);
        read_reg(7'd3, 32'h0, "no_window_bank3");
        read_status(8'd0, 8'd1, 1'b0, "no_window_status");
        vs = 1'b0;
        tick();
        read_reg(7'd3, 32'h0000_1234, "drained_bank3");
        read_status(8'd0, 8'd0, 1'b0, "drained_status");
        read_reg(7'h7D, 32'd1, "frame_one");

        // Overfill, then drain in order with last-write-wins
        vs = 1'b1;
        tick();
        for (int i = 0; i < 8; i++)
            push_wr(7'd5 + 7'(i % 7), 32'hA000_0000 + 32'(i));
        check("full_ready_low", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_addr = 7'd5; wr_data = 32'hA000_0008;
        read_status(8'd0, 8'd8, 1'b0, "full_held");
        vs = 1'b0;
        push_wr(7'd5, 32'hA000_0008);
        repeat (10) tick();
        read_status(8'd0, 8'd0, 1'b0, "overfill_drained");
        for (int a = 3; a <= 12; a++) read_reg(7'(a), exp_bank[a], "overfill_bank");
        read_reg(7'h7D, frame_m, "frame_two");

        // Out-of-range writes are dropped
        push_wr(7'h50, 32'hBAD0_0001);
        push_wr(7'h7C, 32'hBAD0_0002);
        repeat (3) tick();
        read_status(8'd2, 8'd0, 1'b0, "drop_two");
        read_reg(7'h7C, cyc_m, "cycle_cnt_b");
        for (int i = 0; i < 300; i++) push_wr(7'h60, 32'(i));
        repeat (3) tick();
        read_status(8'd255, 8'd0, 1'b0, "drop_saturate");

        // Freeze holds the bank while the FIFO fills
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) push_wr(7'd12 + 7'(i), 32'hC000_0000 + 32'(i));
        read_status(8'd255, 8'd4, 1'b1, "freeze_status");
        read_reg(7'd13, 32'h0, "freeze_bank13");
        freeze = 1'b0;
        repeat (4) tick();
        read_status(8'd255, 8'd0, 1'b0, "unfreeze_drained");
        for (int a = 12; a <= 15; a++) read_reg(7'(a), exp_bank[a], "unfreeze_bank");

        // clr mid-drain
        vs = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push_wr(7'd16 + 7'(i), 32'hD000_0000 + 32'(i));
        vs = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        clear_model();
        read_status(8'd0, 8'd0, 1'b0, "clr_status");
        read_reg(7'd16, exp_bank[16], "clr_bank16");
        read_reg(7'd3, exp_bank[3], "clr_bank3");
        read_reg(7'h7C, cyc_m, "clr_cycle_cnt");
        read_reg(7'h7D, frame_m, "clr_frame_cnt");

        // rstn mid-drain
        vs = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push_wr(7'd21 + 7'(i), 32'hE000_0000 + 32'(i));
        vs = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        clear_model();
        read_reg(7'h7C, cyc_m, "rst_cycle_restart");
        read_status(8'd0, 8'd0, 1'b0, "rst_status");
        read_reg(7'd21, exp_bank[21], "rst_bank21");
        read_reg(7'h7D, frame_m, "rst_frame_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
